// File: rtl/uart_tx_serializer.sv
// Pops one byte per frame from a show-ahead TX FIFO and serialises start/8 data LSB-first/[parity]/stop onto tx.
// Start bit begins the cycle after the capture edge; no pop while tx_enable=0, the FIFO is empty, or a frame is in flight.
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] fifo_data,
  input  logic       fifo_empty,
  output logic       fifo_rd_en,
  input  logic       tx_enable,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic          PAR_INV   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic          rd_en_q, rd_en_d;
  logic          tx_q, tx_d;
  logic          done_q, done_d;
  logic          bit_end;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    rd_en_d = 1'b0;
    bit_end = (cnt_q == CNT_LAST);

    if (state_q != IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + CW'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (tx_enable && !fifo_empty) begin
          shift_d = fifo_data;
          par_d   = ^fifo_data;
          rd_en_d = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (idx_q == 3'd7) begin
            idx_d   = '0;
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          idx_d   = '0;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (idx_q == STOP_LAST) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level is computed from next-state values so tx leaves a flop aligned with the state.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_d ^ PAR_INV;
      default: tx_d = 1'b1;
    endcase

    done_d = (state_d == STOP) && (cnt_d == CNT_LAST) && (idx_d == STOP_LAST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      rd_en_q <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      rd_en_q <= rd_en_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  assign fifo_rd_en = rd_en_q;
  assign tx         = tx_q;
  assign tx_done    = done_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: four instances (8N1, 8E1, 8O1, 8N2) share one FIFO model steered by sel.
// Bytes are scoreboarded on push and compared against per-cycle frames decoded from tx.
module tb_uart_tx_serializer;
  localparam int CPB = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic tx_enable = 1'b0;
  logic [7:0] fifo_data_m = 8'h00;
  logic fifo_empty_m = 1'b1;
  int sel = 0;

  logic [3:0] fe_w, rd_w, tx_w, busy_w, done_w;
  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  int gap_q[$];

  int checks = 0, errors = 0;
  int cyc = 0, pops = 0, frames = 0, stray_rd = 0, stray_done = 0;
  int rd_cyc = -1, start_cyc = -1, last_end = -1, frame_len = 40;
  bit in_frame = 1'b0;
  int fr_pos = 0;
  logic [63:0] obs_vec, obs_done, last_vec, exp_vec;
  logic cur_tx, cur_busy, cur_rd, cur_done;

  always #5 clk = ~clk;

  assign fe_w[0] = (sel != 0) || fifo_empty_m;
  assign fe_w[1] = (sel != 1) || fifo_empty_m;
  assign fe_w[2] = (sel != 2) || fifo_empty_m;
  assign fe_w[3] = (sel != 3) || fifo_empty_m;

  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_d0 (
    .clk(clk), .reset(reset), .fifo_data(fifo_data_m), .fifo_empty(fe_w[0]), .fifo_rd_en(rd_w[0]),
    .tx_enable(tx_enable), .tx(tx_w[0]), .busy(busy_w[0]), .tx_done(done_w[0]));
  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_d1 (
    .clk(clk), .reset(reset), .fifo_data(fifo_data_m), .fifo_empty(fe_w[1]), .fifo_rd_en(rd_w[1]),
    .tx_enable(tx_enable), .tx(tx_w[1]), .busy(busy_w[1]), .tx_done(done_w[1]));
  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_d2 (
    .clk(clk), .reset(reset), .fifo_data(fifo_data_m), .fifo_empty(fe_w[2]), .fifo_rd_en(rd_w[2]),
    .tx_enable(tx_enable), .tx(tx_w[2]), .busy(busy_w[2]), .tx_done(done_w[2]));
  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_d3 (
    .clk(clk), .reset(reset), .fifo_data(fifo_data_m), .fifo_empty(fe_w[3]), .fifo_rd_en(rd_w[3]),
    .tx_enable(tx_enable), .tx(tx_w[3]), .busy(busy_w[3]), .tx_done(done_w[3]));

  // Expected per-cycle line image of one frame for instance s.
  function automatic logic [63:0] exp_frame(input logic [7:0] b, input int s);
    logic [15:0] bits;
    logic [63:0] v;
    int n;
    bits = '0;
    v = '0;
    n = 0;
    bits[n] = 1'b0; n++;
    for (int k = 0; k < 8; k++) begin bits[n] = b[k]; n++; end
    if (s == 1 || s == 2) begin bits[n] = (^b) ^ (s == 2); n++; end
    bits[n] = 1'b1; n++;
    if (s == 3) begin bits[n] = 1'b1; n++; end
    for (int k = 0; k < n; k++)
      for (int c = 0; c < CPB; c++) v[k*CPB+c] = bits[k];
    return v;
  endfunction

  task automatic refresh();
    fifo_empty_m = (fifo_q.size() == 0);
    fifo_data_m  = (fifo_q.size() != 0) ? fifo_q[0] : 8'($urandom);
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    exp_q.push_back(b);
    refresh();
  endtask

  task automatic set_sel(input int s);
    sel = s;
    frame_len = ((s == 0) ? 10 : 11) * CPB;
    last_end = -1;
    gap_q.delete();
  endtask

  // One clock: sample on the falling edge, model the FIFO pop, decode and score frames.
  task automatic step();
    @(negedge clk);
    cyc++;
    cur_tx = tx_w[sel]; cur_busy = busy_w[sel]; cur_rd = rd_w[sel]; cur_done = done_w[sel];
    if ((rd_w & ~(4'd1 << sel)) != 4'd0) stray_rd++;
    if (cur_rd) begin
      pops++;
      rd_cyc = cyc;
      if (fifo_q.size() != 0) void'(fifo_q.pop_front());
    end
    if (!in_frame && cur_tx == 1'b0) begin
      in_frame = 1'b1;
      fr_pos = 0;
      obs_vec = '0;
      obs_done = '0;
      start_cyc = cyc;
      if (last_end >= 0) gap_q.push_back(cyc - last_end - 1);
    end
    if (in_frame) begin
      obs_vec[fr_pos] = cur_tx;
      obs_done[fr_pos] = cur_done;
      fr_pos++;
      if (fr_pos == frame_len) begin
        in_frame = 1'b0;
        last_end = cyc;
        last_vec = obs_vec;
        frames++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL frame_unexpected: got frame %h, required none", obs_vec);
        end else begin
          exp_vec = exp_frame(exp_q.pop_front(), sel);
          if (obs_vec !== exp_vec) begin
            errors++;
            $display("FAIL frame_bits dut%0d: got %h, required %h", sel, obs_vec, exp_vec);
          end
        end
        checks++;
        if (obs_done !== (64'd1 << (frame_len - 1))) begin
          errors++;
          $display("FAIL tx_done_pos dut%0d: got %h, required %h", sel, obs_done, 64'd1 << (frame_len - 1));
        end
      end
    end else if (cur_done) begin
      stray_done++;
    end
    refresh();
  endtask

  task automatic run_until(input int target, input int budget, output bit ok);
    int n = 0;
    while (frames < target && n < budget) begin step(); n++; end
    ok = (frames >= target);
  endtask

  task automatic test_reset();
    int bad_tx = 0, bad_busy = 0, p0;
    #2 reset = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({tx_w[i], busy_w[i], rd_w[i], done_w[i]} !== 4'b1000) begin
        errors++;
        $display("FAIL reset_state dut%0d: got tx/busy/rd/done=%b, required 1000", i,
                 {tx_w[i], busy_w[i], rd_w[i], done_w[i]});
      end
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    tx_enable = 1'b1;
    p0 = pops;
    for (int i = 0; i < 100; i++) begin
      step();
      if (tx_w !== 4'hF) bad_tx++;
      if (busy_w !== 4'h0) bad_busy++;
      if (rd_w !== 4'h0) pops++;
    end
    checks++;
    if (pops - p0 != 0) begin errors++; $display("FAIL idle_pop: got %0d pops, required 0", pops - p0); end
    checks++;
    if (bad_tx != 0) begin errors++; $display("FAIL idle_tx: got %0d low cycles, required 0", bad_tx); end
    checks++;
    if (bad_busy != 0) begin errors++; $display("FAIL idle_busy: got %0d busy cycles, required 0", bad_busy); end
  endtask

  task automatic test_single();
    int p0 = pops;
    bit ok;
    set_sel(0);
    push(8'hA5);
    run_until(frames + 1, 100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_timeout: got no frame, required 1"); end
    checks++;
    if (pops - p0 != 1) begin errors++; $display("FAIL single_pops: got %0d, required 1", pops - p0); end
    checks++;
    if (start_cyc != rd_cyc) begin
      errors++;
      $display("FAIL start_latency: got start cycle %0d, required %0d", start_cyc, rd_cyc);
    end
    step();
    checks++;
    if ({cur_busy, cur_tx} !== 2'b01) begin
      errors++;
      $display("FAIL single_after: got busy/tx=%b, required 01", {cur_busy, cur_tx});
    end
  endtask

  task automatic test_parity();
    bit ok;
    set_sel(1);
    push(8'hA5);
    run_until(frames + 1, 100, ok);
    checks++;
    if (!ok || last_vec[9*CPB+1] !== 1'b0) begin
      errors++;
      $display("FAIL parity_even_a5: got %b (ok=%0d), required 0", last_vec[9*CPB+1], ok);
    end
    push(8'h01);
    run_until(frames + 1, 100, ok);
    checks++;
    if (!ok || last_vec[9*CPB+1] !== 1'b1) begin
      errors++;
      $display("FAIL parity_even_01: got %b (ok=%0d), required 1", last_vec[9*CPB+1], ok);
    end
    set_sel(2);
    push(8'hA5);
    run_until(frames + 1, 100, ok);
    checks++;
    if (!ok || last_vec[9*CPB+1] !== 1'b1) begin
      errors++;
      $display("FAIL parity_odd_a5: got %b (ok=%0d), required 1", last_vec[9*CPB+1], ok);
    end
  endtask

  task automatic test_back_to_back();
    int p0 = pops;
    bit ok;
    set_sel(0);
    push(8'h00); push(8'hFF); push(8'h3C);
    run_until(frames + 3, 200, ok);
    checks++;
    if (!ok || pops - p0 != 3) begin
      errors++;
      $display("FAIL b2b_pops: got %0d pops (ok=%0d), required 3", pops - p0, ok);
    end
    checks++;
    if (gap_q.size() != 2) begin
      errors++;
      $display("FAIL b2b_gap_count: got %0d, required 2", gap_q.size());
    end
    foreach (gap_q[i]) begin
      checks++;
      if (gap_q[i] != 1) begin errors++; $display("FAIL b2b_gap: got %0d idle clk, required 1", gap_q[i]); end
    end
    set_sel(3);
    push(8'h3C); push(8'h81);
    run_until(frames + 2, 150, ok);
    checks++;
    if (!ok || last_vec[11*CPB-1:9*CPB] !== 8'hFF) begin
      errors++;
      $display("FAIL stop2_len: got %b (ok=%0d), required 11111111", last_vec[11*CPB-1:9*CPB], ok);
    end
    checks++;
    if (gap_q.size() != 1 || gap_q[0] != 1) begin
      errors++;
      $display("FAIL stop2_gap: got %0d gaps, required one gap of 1", gap_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int p0, n = 0;
    bit ok;
    set_sel(0);
    push(8'h55);
    while (!(in_frame && fr_pos == CPB + 3*CPB + 2) && n < 100) begin step(); n++; end
    checks++;
    if (n >= 100) begin errors++; $display("FAIL rst_mid_reach: got no DATA bit 3, required reached"); end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({tx_w[0], busy_w[0]} !== 2'b10) begin
      errors++;
      $display("FAIL rst_mid_async: got tx/busy=%b, required 10", {tx_w[0], busy_w[0]});
    end
    p0 = pops;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (rd_w[0] !== 1'b0) begin errors++; $display("FAIL rst_mid_pop: got rd_en=%b, required 0", rd_w[0]); end
    end
    reset = 1'b0;
    in_frame = 1'b0;
    fr_pos = 0;
    exp_q.delete();
    last_end = -1;
    push(8'h96);
    run_until(frames + 1, 100, ok);
    checks++;
    if (!ok || pops - p0 != 1) begin
      errors++;
      $display("FAIL rst_mid_next: got %0d pops (ok=%0d), required 1", pops - p0, ok);
    end
  endtask

  task automatic test_enable_drop();
    int p0 = pops, f0 = frames, n = 0;
    bit ok;
    set_sel(0);
    push(8'hC3); push(8'h5A);
    while (!in_frame && n < 20) begin step(); n++; end
    tx_enable = 1'b0;
    run_until(f0 + 1, 100, ok);
    repeat (30) step();
    checks++;
    if (!ok || frames - f0 != 1) begin
      errors++;
      $display("FAIL en_drop_frames: got %0d (ok=%0d), required 1", frames - f0, ok);
    end
    checks++;
    if (pops - p0 != 1 || fifo_q.size() != 1) begin
      errors++;
      $display("FAIL en_drop_pops: got %0d pops, %0d queued, required 1 and 1", pops - p0, fifo_q.size());
    end
    tx_enable = 1'b1;
    run_until(f0 + 2, 100, ok);
    checks++;
    if (!ok || pops - p0 != 2) begin
      errors++;
      $display("FAIL en_resume: got %0d pops (ok=%0d), required 2", pops - p0, ok);
    end
  endtask

  task automatic test_isolation();
    checks++;
    if (stray_rd != 0) begin errors++; $display("FAIL stray_pop: got %0d, required 0", stray_rd); end
    checks++;
    if (stray_done != 0) begin errors++; $display("FAIL stray_done: got %0d, required 0", stray_done); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_left: got %0d bytes, required 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_parity();
    test_back_to_back();
    test_reset_mid();
    test_enable_drop();
    test_isolation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required finish before 200000");
    $fatal(1);
  end

endmodule
